// File: rtl/data_mem_delay.sv
// data_mem_delay: data memory responder for the MIPS M stage.
// Build option DMEM_DELAY_EN:
//   defined   - each load/store holds the pipeline (StallMem) for LATENCY
//               cycles, then completes with a one-cycle MemReadyM strobe.
//   undefined - zero-wait memory: stores write on the request edge, loads
//               read combinationally, MemReadyM=1 and StallMem=0.
// RAM keeps its fixed name so benches can reach it hierarchically.
// The word index needs DEPTH <= 2**29 so that at least one high address bit
// is left over for aliasing.
module data_mem_delay #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemReadyM,
  output logic        StallMem
);

  localparam int AW = $clog2(DEPTH);

  // Word storage; contents are never cleared by reset.
  logic [31:0] RAM [0:DEPTH-1];

  // Word index; byte offset and high bits are dropped, so addresses wrap.
  logic [AW-1:0] idx;
  assign idx = ALUOutM[AW+1:2];

`ifdef DMEM_DELAY_EN

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Counter start so that BUSY lasts LATENCY-1 cycles (unused when LATENCY==1).
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

  logic          request;
  state_t        state_reg;
  logic [3:0]    cnt_reg;
  logic [AW-1:0] addr_reg;
  logic [31:0]   data_reg;
  logic          write_reg;

  assign request = MemReadM | MemWriteM;

  // Hold the pipeline while a request is outstanding but not yet complete.
  assign StallMem = request & ~MemReadyM;

  // Access sequencer: latch the request, count down, then strobe completion.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      write_reg <= 1'b0;
      ReadDataM <= '0;
      MemReadyM <= 1'b0;
    end else begin
      MemReadyM <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (request) begin
            addr_reg  <= idx;
            data_reg  <= WriteDataM;
            write_reg <= MemWriteM;
            if (LATENCY == 1) begin
              // Single-cycle access: finish straight from the request cycle.
              state_reg <= DONE;
              MemReadyM <= 1'b1;
              if (!MemWriteM) begin
                ReadDataM <= RAM[idx];
              end
            end else begin
              state_reg <= BUSY;
              cnt_reg   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          // Inputs are ignored here; only the latched request matters.
          if (cnt_reg == 4'd0) begin
            state_reg <= DONE;
            MemReadyM <= 1'b1;
            if (!write_reg) begin
              ReadDataM <= RAM[addr_reg];
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Commit a store at the end of DONE; a reset in that cycle discards it.
  always_ff @(posedge CLK) begin
    if (CLR && (state_reg == DONE) && write_reg) begin
      RAM[addr_reg] <= data_reg;
    end
  end

  logic unused_addr;
  assign unused_addr = &{1'b0, ALUOutM[31:AW+2], ALUOutM[1:0]};

`else

  // Zero-wait store: write on the edge that closes the request cycle.
  always_ff @(posedge CLK) begin
    if (CLR && MemWriteM) begin
      RAM[idx] <= WriteDataM;
    end
  end

  assign ReadDataM = RAM[idx];
  assign MemReadyM = 1'b1;
  assign StallMem  = 1'b0;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ALUOutM[31:AW+2], ALUOutM[1:0], MemReadM,
                           1'(LATENCY)};

`endif

endmodule

// File: tb/tb_data_mem_delay.sv
// tb_data_mem_delay: directed bench for data_mem_delay. Covers the delayed
// FSM build (DMEM_DELAY_EN defined) and the zero-wait default build.
`timescale 1ns/1ps
module tb_data_mem_delay;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemReadyM;
  logic        StallMem;

  int checks = 0;
  int errors = 0;

`ifdef DMEM_DELAY_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 0;
`endif

  data_mem_delay #(.DEPTH(256), .LATENCY(4)) dut (
    .CLK(CLK), .CLR(CLR), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
    .MemReadyM(MemReadyM), .StallMem(StallMem)
  );

`ifdef DMEM_DELAY_EN
  logic [31:0] ReadDataM1;
  logic        MemReadyM1;
  logic        StallMem1;

  data_mem_delay #(.DEPTH(256), .LATENCY(1)) dut1 (
    .CLK(CLK), .CLR(CLR), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM1),
    .MemReadyM(MemReadyM1), .StallMem(StallMem1)
  );
`endif

  always #5 CLK = ~CLK;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Issue one access in the current cycle and hold it until MemReadyM.
  // Returns stall cycles seen, stall-level violations and the data at completion.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output int bad,
                        output logic [31:0] rdata);
    MemReadM = rd; MemWriteM = wr; ALUOutM = a; WriteDataM = d;
    #1;
    lat = 0;
    bad = 0;
    while (MemReadyM !== 1'b1 && lat < 40) begin
      if (StallMem !== 1'b1) bad++;
      lat++;
      next_cycle();
    end
    if (StallMem !== 1'b0) bad++;
    rdata = ReadDataM;
    $display("access rd=%0d wr=%0d addr=%h wdata=%h stall_cycles=%0d rdata=%h",
             rd, wr, a, d, lat, rdata);
    next_cycle();
    MemReadM = 1'b0;
    MemWriteM = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    CLR = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
    ALUOutM = '0; WriteDataM = '0;
    repeat (3) next_cycle();
    checks++;
    if (StallMem !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b expected 0", StallMem);
    end
`ifdef DMEM_DELAY_EN
    checks++;
    if (MemReadyM !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b expected 0", MemReadyM);
    end
    checks++;
    if (ReadDataM !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 00000000", ReadDataM);
    end
`else
    checks++;
    if (MemReadyM !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", MemReadyM);
    end
`endif
    CLR = 1'b1;
    next_cycle();
  endtask

  task automatic test_store_load();
    int lat, bad;
    logic [31:0] rd;
    access(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, lat, bad, rd);
    checks++;
    if (lat != EXP_LAT || bad != 0) begin
      errors++; $display("FAIL store_latency: got %0d (bad stall %0d) expected %0d", lat, bad, EXP_LAT);
    end
    checks++;
    if (dut.RAM[16] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_ram: got %h expected deadbeef", dut.RAM[16]);
    end
    access(1'b1, 1'b0, 32'h40, 32'h0, lat, bad, rd);
    checks++;
    if (lat != EXP_LAT || bad != 0) begin
      errors++; $display("FAIL load_latency: got %0d (bad stall %0d) expected %0d", lat, bad, EXP_LAT);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_data: got %h expected deadbeef", rd);
    end
  endtask

  task automatic test_alias();
    int lat, bad;
    logic [31:0] rd;
    access(1'b0, 1'b1, 32'h400, 32'h1234, lat, bad, rd);
    checks++;
    if (dut.RAM[0] !== 32'h1234) begin
      errors++; $display("FAIL alias_ram: got %h expected 00001234", dut.RAM[0]);
    end
    access(1'b1, 1'b0, 32'h000, 32'h0, lat, bad, rd);
    checks++;
    if (rd !== 32'h1234 || lat != EXP_LAT) begin
      errors++; $display("FAIL alias_load0: got %h lat %0d expected 00001234 lat %0d", rd, lat, EXP_LAT);
    end
    access(1'b1, 1'b0, 32'h403, 32'h0, lat, bad, rd);
    checks++;
    if (rd !== 32'h1234 || lat != EXP_LAT) begin
      errors++; $display("FAIL alias_load403: got %h lat %0d expected 00001234 lat %0d", rd, lat, EXP_LAT);
    end
  endtask

  task automatic test_both();
    int lat, bad;
    logic [31:0] rd;
    access(1'b1, 1'b1, 32'h80, 32'h55, lat, bad, rd);
    checks++;
    if (lat != EXP_LAT || bad != 0) begin
      errors++; $display("FAIL both_latency: got %0d (bad stall %0d) expected %0d", lat, bad, EXP_LAT);
    end
    checks++;
    if (dut.RAM[32] !== 32'h55) begin
      errors++; $display("FAIL both_ram: got %h expected 00000055", dut.RAM[32]);
    end
`ifdef DMEM_DELAY_EN
    checks++;
    if (ReadDataM !== 32'h1234) begin
      errors++; $display("FAIL both_rdata_held: got %h expected 00001234", ReadDataM);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int lat, bad;
    logic [31:0] rd;
    logic [31:0] vals [3];
    vals[0] = 32'hA0A0_0001; vals[1] = 32'hB1B1_0002; vals[2] = 32'hC2C2_0003;
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 1'b1, 32'h100 + 32'(4 * i), vals[i], lat, bad, rd);
      checks++;
      if (lat != EXP_LAT || bad != 0) begin
        errors++; $display("FAIL b2b_store_latency[%0d]: got %0d expected %0d", i, lat, EXP_LAT);
      end
    end
    for (int i = 0; i < 3; i++) begin
      access(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h0, lat, bad, rd);
      checks++;
      if (rd !== vals[i] || lat != EXP_LAT) begin
        errors++; $display("FAIL b2b_load[%0d]: got %h lat %0d expected %h lat %0d", i, rd, lat, vals[i], EXP_LAT);
      end
    end
  endtask

  task automatic test_ram_survives_reset();
    CLR = 1'b0;
    repeat (2) next_cycle();
    CLR = 1'b1;
    next_cycle();
    checks++;
    if (dut.RAM[16] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL reset_keeps_ram: got %h expected deadbeef", dut.RAM[16]);
    end
  endtask

`ifdef DMEM_DELAY_EN
  task automatic test_flush();
    int n, bad;
    MemWriteM = 1'b1; ALUOutM = 32'h10; WriteDataM = 32'h77;
    #1;
    checks++;
    if (StallMem !== 1'b1) begin
      errors++; $display("FAIL flush_first_stall: got %b expected 1", StallMem);
    end
    next_cycle();
    MemWriteM = 1'b0;
    #1;
    n = 1;
    bad = 0;
    while (MemReadyM !== 1'b1 && n < 40) begin
      if (StallMem !== 1'b0) bad++;
      next_cycle();
      n++;
    end
    checks++;
    if (n != 4 || bad != 0) begin
      errors++; $display("FAIL flush_ready: got cycle %0d (bad stall %0d) expected 4", n, bad);
    end
    next_cycle();
    checks++;
    if (dut.RAM[4] !== 32'h77) begin
      errors++; $display("FAIL flush_ram: got %h expected 00000077", dut.RAM[4]);
    end
  endtask

  task automatic test_reset_mid_store();
    int lat, bad, pulses;
    logic [31:0] rd;
    access(1'b0, 1'b1, 32'h24, 32'hCAFEF00D, lat, bad, rd);
    access(1'b0, 1'b1, 32'h20, 32'h11111111, lat, bad, rd);
    MemWriteM = 1'b1; ALUOutM = 32'h20; WriteDataM = 32'h99;
    next_cycle();          // BUSY cycle 1
    next_cycle();          // BUSY cycle 2
    CLR = 1'b0;
    next_cycle();
    CLR = 1'b1;
    MemWriteM = 1'b0;
    #1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (MemReadyM === 1'b1) pulses++;
      next_cycle();
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL abort_no_ready: got %0d pulses expected 0", pulses);
    end
    checks++;
    if (dut.RAM[8] !== 32'h11111111) begin
      errors++; $display("FAIL abort_ram_target: got %h expected 11111111", dut.RAM[8]);
    end
    checks++;
    if (dut.RAM[9] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL abort_ram_other: got %h expected cafef00d", dut.RAM[9]);
    end
    access(1'b1, 1'b0, 32'h24, 32'h0, lat, bad, rd);
    checks++;
    if (lat != 4 || rd !== 32'hCAFEF00D) begin
      errors++; $display("FAIL abort_then_load: got lat %0d data %h expected lat 4 data cafef00d", lat, rd);
    end
  endtask

  task automatic test_latency1();
    repeat (3) next_cycle();
    MemReadM = 1'b1; ALUOutM = 32'h40;
    #1;
    checks++;
    if (StallMem1 !== 1'b1 || MemReadyM1 !== 1'b0) begin
      errors++; $display("FAIL lat1_request_cycle: got stall %b ready %b expected stall 1 ready 0", StallMem1, MemReadyM1);
    end
    next_cycle();
    $display("access lat1 rd=1 addr=00000040 ready=%b rdata=%h", MemReadyM1, ReadDataM1);
    checks++;
    if (MemReadyM1 !== 1'b1 || StallMem1 !== 1'b0) begin
      errors++; $display("FAIL lat1_done_cycle: got ready %b stall %b expected ready 1 stall 0", MemReadyM1, StallMem1);
    end
    checks++;
    if (ReadDataM1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lat1_data: got %h expected deadbeef", ReadDataM1);
    end
    MemReadM = 1'b0;
    repeat (6) next_cycle();
  endtask
`else
  task automatic test_no_stall();
    int bad;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      MemReadM = i[0]; MemWriteM = ~i[0]; ALUOutM = 32'h200 + 32'(4 * i);
      WriteDataM = 32'h5000 + 32'(i);
      #1;
      if (StallMem !== 1'b0 || MemReadyM !== 1'b1) bad++;
      next_cycle();
    end
    MemReadM = 1'b0; MemWriteM = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL no_stall: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (dut.RAM[130] !== 32'h5002) begin
      errors++; $display("FAIL zero_wait_store: got %h expected 00005002", dut.RAM[130]);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_alias();
    test_both();
    test_back_to_back();
    test_ram_survives_reset();
`ifdef DMEM_DELAY_EN
    test_flush();
    test_reset_mid_store();
    test_latency1();
`else
    test_no_stall();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_delay.md
# data_mem_delay

- Multi-cycle data memory responder for the pipelined MIPS core's memory (M) stage; replaces the single-cycle data memory.
- Accepts one load or store at a time from the pipeline, which is the initiator.
- Holds the pipeline with a stall signal for a fixed, parameterised number of cycles, then completes the access and pulses a ready strobe.
- The storage array stays hierarchically visible so benches can preload it and dump it.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words; power of two.
- LATENCY, 4: cycles from first request cycle to MemReadyM; legal range 1..15.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- CLR  in  1  reset; synchronous and active-low.
- MemReadM  in  1  load request.
- MemWriteM  in  1  store request.
- ALUOutM  in  32  byte address.
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load data; registered.
- MemReadyM  out  1  one-cycle completion strobe.
- StallMem  out  1  pipeline hold request; combinational.
- Internal array RAM[0:DEPTH-1], 32-bit words; name fixed for hierarchical access.

## Operation
- Word index = ALUOutM[log2(DEPTH)+1:2]. Bits [1:0] and bits above the index are ignored, so out-of-range addresses alias (wrap) into the array.
- Request = MemReadM | MemWriteM. If both are high, the access is a store; ReadDataM is not updated.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on request, latch address, data and op. Go to DONE if LATENCY==1. Otherwise go to BUSY with counter = LATENCY-2.
  - BUSY: decrement the counter. Go to DONE when the counter reaches 0. Input changes are ignored; the latched request is used.
  - DONE:
    - MemReadyM=1 for exactly one cycle.
    - A store writes RAM at the closing edge.
    - A load has ReadDataM already valid in this cycle, loaded at the BUSY→DONE edge (or the IDLE→DONE edge).
    - Always returns to IDLE.
- StallMem = request & ~MemReadyM. It is 1 in the request's first IDLE cycle and all BUSY cycles, and 0 in DONE.
- A request deasserted mid-transaction (flush) still completes. MemReadyM still pulses.
- Back-to-back accesses: the pipeline advances on the DONE edge. The next instruction's request is seen in the following IDLE cycle, so there is no lost and no duplicated access.
- Reset values: state=IDLE, counter=0, ReadDataM=0, MemReadyM=0, StallMem is 0 with no request present.
- Reset does not clear RAM, so preloaded contents survive.
- Reset mid-transaction aborts it: a pending store is discarded and no MemReadyM pulse is generated.

## Timing
- Request first visible in cycle c. MemReadyM=1 in cycle c+LATENCY. StallMem=1 for cycles c..c+LATENCY-1, i.e. exactly LATENCY stall cycles per access.
- Store data is visible in RAM from cycle c+LATENCY+1.
- ReadDataM holds its last load value until the next load completes.
- No combinational path from inputs to ReadDataM or MemReadyM. StallMem depends combinationally on MemReadM and MemWriteM.

## Configuration
- Macro: DMEM_DELAY_EN.
- Defined: the delayed FSM behaviour above.
- Undefined: zero-wait memory.
  - Stores write RAM on the posedge of the request cycle.
  - ReadDataM is a combinational read of RAM.
  - MemReadyM is tied to 1 and StallMem is tied to 0.
  - LATENCY is ignored; the FSM and counter are not built.

## Test plan
- Store then load, LATENCY=4: store 0xDEADBEEF to 0x40 in cycle 10. StallMem=1 in cycles 10–13 and MemReadyM=1 in cycle 14. A load from 0x40 issued in cycle 15 returns ReadDataM=0xDEADBEEF with MemReadyM in cycle 19.
- LATENCY=1: a load takes 1 stall cycle; MemReadyM is asserted the cycle after the request first appears.
- Aliasing: store 0x1234 to 0x400 with DEPTH=256. A load from 0x000 returns 0x1234. A load from 0x403 also returns 0x1234.
- Simultaneous MemReadM and MemWriteM with 0x55 at 0x80: RAM[32]=0x55 and ReadDataM is unchanged.
- Reset mid-store: CLR=0 at BUSY cycle 2. The state returns to IDLE, RAM at the target is unchanged, and no MemReadyM pulse occurs. A $readmemh-preloaded word elsewhere is intact.
- DMEM_DELAY_EN undefined: StallMem stays 0 throughout, and a load returns data in the same cycle as the request.
